classifier_argmax: RTL and testbench
====================================

CLASSIFIER_ARGMAX -- requirements
Module: classifier_argmax

Interface
REQ-001 The block SHALL expose parameter NUM_CLASSES, default 10, meaning the number of output-layer neuron results per frame (legal range 2..16).
REQ-002 The block SHALL expose parameter DATA_W, default 32, meaning the width of one neuron result, treated as two's-complement signed.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset: asynchronous assertion, active-low.
REQ-005 The block SHALL have port in_valid, input, 1, meaning in_data/in_last carry a neuron result.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-007 The block SHALL have port in_data, input, DATA_W, meaning one post-ReLU neuron result, class order 0,1,2,...
REQ-008 The block SHALL have port in_last, input, 1, meaning the producer marks the final result of a frame.
REQ-009 The block SHALL have port out_valid, output, 1, meaning classification result available.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The block SHALL have port out_class, output, CLASS_W=$clog2(NUM_CLASSES), meaning index of the maximum result.
REQ-012 The block SHALL have port out_score, output, DATA_W, meaning the maximum result value.
REQ-013 The block SHALL have port out_err, output, 1, meaning frame length differed from NUM_CLASSES.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM and HOLD; in_ready=1 in IDLE and ACCUM and 0 in HOLD.
REQ-015 A beat SHALL be accepted when in_valid&&in_ready; the count of accepted beats in the current frame is cnt.
REQ-016 In IDLE, an accepted beat SHALL load best=in_data, idx=0, cnt=1 and move to ACCUM, unless the beat ends the frame.
REQ-017 In ACCUM, an accepted beat SHALL replace best/idx only if signed in_data > best (strictly), so ties resolve to the lowest index.
REQ-018 A frame SHALL end on the accepted beat where in_last=1 or cnt reaches NUM_CLASSES, whichever comes first.
REQ-019 On frame end, the FSM SHALL enter HOLD, with out_valid=1 in the following cycle (latency one cycle from final beat).
REQ-020 out_err SHALL be 1 iff the frame ends by in_last before cnt reaches NUM_CLASSES, or cnt reaches NUM_CLASSES with in_last=0.
REQ-021 out_class, out_score and out_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 On out_valid&&out_ready, the FSM SHALL return to IDLE next cycle with out_valid=0; there is no overlap of the next frame with HOLD.
REQ-023 Beats presented with in_ready=0 SHALL be ignored, and the producer holds them.
REQ-024 Comparison SHALL use the full DATA_W signed compare, with no truncation or saturation.

Reset
REQ-025 While rst_n=0, the block SHALL hold state=IDLE, in_ready=0, out_valid=0, out_class=0, out_score=0, out_err=0, cnt=0, and (if enabled) out_margin=0.
REQ-026 Reset asserted mid-frame or in HOLD SHALL discard the partial or held result, and the first beat after release SHALL start a new frame.

Configuration
REQ-027 With macro ARGMAX_MARGIN_EN defined, the block SHALL add output port out_margin, DATA_W, equal to best minus runner-up value, tracking the runner-up on every beat.
REQ-028 When the best value is tied, out_margin SHALL be 0, and it SHALL saturate at the signed maximum on overflow.
REQ-029 Without ARGMAX_MARGIN_EN, the port and runner-up register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package nn_pkg SHALL hold DATA_W default, NUM_CLASSES default, the CLASS_W function, and the FSM state enum.
REQ-031 A single sub-module argmax_cmp SHALL implement the combinational signed compare-and-select of the candidate against the stored best (and runner-up).

Verification
REQ-032 The bench SHALL feed 10 beats [0,5,3,9,2,9,1,0,4,7] with in_last on beat 9, and require out_class=3, out_score=9, out_err=0, out_valid exactly 1 cycle after the last beat.
REQ-033 The bench SHALL feed all zeros ×10, and require out_class=0, out_score=0, out_err=0; with ARGMAX_MARGIN_EN, out_margin=0.
REQ-034 The bench SHALL feed 6 beats with in_last on beat 5 of [1,2,8,3,0,0], and require out_class=2, out_err=1; then feed 10 beats with in_last never set, and require out_err=1 at beat 9.
REQ-035 The bench SHALL hold out_ready=0 for 20 cycles in HOLD while driving in_valid=1, and require in_ready=0, outputs stable, and no beat consumed.
REQ-036 The bench SHALL assert rst_n=0 after beat 4, then send [0,0,0,0,0,0,0,0,0,7], and require out_class=9, out_score=7, out_err=0.
REQ-037 The bench SHALL feed values 32'h7FFF_FFFF at class 1 and 32'h8000_0000 elsewhere (margin build), and require out_class=1 and out_margin=32'h7FFF_FFFF (saturated).

Source files
------------

// File: rtl/nn_pkg.sv
// Shared defaults, class-index width helper and FSM state encoding for the
// classifier output stage.
package nn_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_NUM_CLASSES = 10;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    function automatic int class_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare-and-select of one candidate against the stored
// best (and runner-up when ARGMAX_MARGIN_EN is defined).
module argmax_cmp #(
    parameter int DATA_W  = 32,
    parameter int CLASS_W = 4
) (
    input  logic               first,
    input  logic [DATA_W-1:0]  cand,
    input  logic [CLASS_W-1:0] cand_idx,
    input  logic [DATA_W-1:0]  best,
    input  logic [CLASS_W-1:0] best_idx,
`ifdef ARGMAX_MARGIN_EN
    input  logic [DATA_W-1:0]  second,
    output logic [DATA_W-1:0]  new_second,
    output logic [DATA_W-1:0]  margin,
`endif
    output logic [DATA_W-1:0]  new_best,
    output logic [CLASS_W-1:0] new_idx
);

    logic take;

    // Strict compare keeps the lowest index on ties.
    assign take     = first || ($signed(cand) > $signed(best));
    assign new_best = take ? cand : best;
    assign new_idx  = take ? cand_idx : best_idx;

`ifdef ARGMAX_MARGIN_EN
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W:0] diff;

    always_comb begin
        new_second = second;
        if (first)
            new_second = S_MIN;
        else if (take)
            new_second = best;
        else if ($signed(cand) > $signed(second))
            new_second = cand;
    end

    // best >= second, so the only possible overflow is past the signed maximum.
    assign diff   = {new_best[DATA_W-1], new_best} - {new_second[DATA_W-1], new_second};
    assign margin = (diff[DATA_W] ^ diff[DATA_W-1]) ? S_MAX : diff[DATA_W-1:0];
`endif

endmodule

// File: rtl/classifier_argmax.sv
// Streams NUM_CLASSES signed neuron results per frame and reports the argmax.
// Define ARGMAX_MARGIN_EN to add out_margin (best minus runner-up, saturated).
module classifier_argmax
    import nn_pkg::*;
#(
    parameter  int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter  int DATA_W      = DEF_DATA_W,
    localparam int CLASS_W     = class_w(NUM_CLASSES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic [DATA_W-1:0]  out_score,
`ifdef ARGMAX_MARGIN_EN
    output logic [DATA_W-1:0]  out_margin,
`endif
    output logic               out_err
);

    localparam int CNT_W = $clog2(NUM_CLASSES + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [DATA_W-1:0]  best, new_best;
    logic [CLASS_W-1:0] idx, new_idx;
    logic               accept, full, frame_end;

    assign accept    = in_valid && in_ready;
    assign cnt_next  = cnt + 1'b1;
    assign full      = (cnt_next == CNT_W'(NUM_CLASSES));
    assign frame_end = accept && (in_last || full);

`ifdef ARGMAX_MARGIN_EN
    logic [DATA_W-1:0] second, new_second, margin;
`endif

    argmax_cmp #(.DATA_W(DATA_W), .CLASS_W(CLASS_W)) u_cmp (
        .first      (state == IDLE),
        .cand       (in_data),
        .cand_idx   (CLASS_W'(cnt)),
        .best       (best),
        .best_idx   (idx),
`ifdef ARGMAX_MARGIN_EN
        .second     (second),
        .new_second (new_second),
        .margin     (margin),
`endif
        .new_best   (new_best),
        .new_idx    (new_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_score <= '0;
            out_err   <= 1'b0;
            cnt       <= '0;
            best      <= '0;
            idx       <= '0;
`ifdef ARGMAX_MARGIN_EN
            second     <= '0;
            out_margin <= '0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready <= !frame_end;
                    if (accept) begin
                        best <= new_best;
                        idx  <= new_idx;
                        cnt  <= cnt_next;
`ifdef ARGMAX_MARGIN_EN
                        second <= new_second;
`endif
                        if (frame_end) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_class <= new_idx;
                            out_score <= new_best;
                            out_err   <= !(in_last && full);
`ifdef ARGMAX_MARGIN_EN
                            out_margin <= margin;
`endif
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Result registers stay untouched until the consumer takes them.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        cnt       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_classifier_argmax.sv
// Directed table-driven bench for classifier_argmax plus hold and reset sequences.
module tb_classifier_argmax;

    localparam int N = 10;
    localparam int W = 32;
    localparam logic [W-1:0] S_MIN = 32'h8000_0000;
    localparam logic [W-1:0] S_MAX = 32'h7FFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [3:0]   out_class;
    logic [W-1:0] out_score;
    logic         out_err;
`ifdef ARGMAX_MARGIN_EN
    logic [W-1:0] out_margin;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    classifier_argmax #(.NUM_CLASSES(N), .DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_score  (out_score),
`ifdef ARGMAX_MARGIN_EN
        .out_margin (out_margin),
`endif
        .out_err    (out_err)
    );

    typedef struct {
        logic [W-1:0] d [N];
        int           len;
        int           last_at;
        int           ecls;
        logic [W-1:0] escore;
        logic         eerr;
        logic [W-1:0] emargin;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [W-1:0] d, input logic last, output logic ov_before);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        ov_before = out_valid;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string name, input int ecls, input logic [W-1:0] escore,
                                input logic eerr, input logic [W-1:0] emargin);
        chk({name, "_class"}, W'(out_class), W'(ecls));
        chk({name, "_score"}, out_score, escore);
        chk({name, "_err"}, W'(out_err), W'(eerr));
`ifdef ARGMAX_MARGIN_EN
        chk({name, "_margin"}, out_margin, emargin);
`else
        if (emargin === 'x) $display("note: no margin for %s", name);
`endif
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_valid_drop"}, W'(out_valid), '0);
    endtask

    task automatic send_row(input int i);
        logic ovb;
        logic ovlast = 1'b0;
        string nm = $sformatf("row%0d", i);
        for (int b = 0; b < tv[i].len; b++) begin
            push_beat(tv[i].d[b], logic'(b == tv[i].last_at), ovb);
            if (b == tv[i].len - 1) ovlast = ovb;
        end
        chk({nm, "_latency"}, W'({ovlast, out_valid}), W'(2'b01));
        check_result(nm, tv[i].ecls, tv[i].escore, tv[i].eerr, tv[i].emargin);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ovb;
        int   bad;

        tv[0].d = '{0, 5, 3, 9, 2, 9, 1, 0, 4, 7};
        tv[0].len = 10; tv[0].last_at = 9; tv[0].ecls = 3; tv[0].escore = 9;
        tv[0].eerr = 0; tv[0].emargin = 0;
        tv[1].d = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[1].len = 10; tv[1].last_at = 9; tv[1].ecls = 0; tv[1].escore = 0;
        tv[1].eerr = 0; tv[1].emargin = 0;
        tv[2].d = '{1, 2, 8, 3, 0, 0, 0, 0, 0, 0};
        tv[2].len = 6; tv[2].last_at = 5; tv[2].ecls = 2; tv[2].escore = 8;
        tv[2].eerr = 1; tv[2].emargin = 5;
        tv[3].d = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        tv[3].len = 10; tv[3].last_at = -1; tv[3].ecls = 5; tv[3].escore = 9;
        tv[3].eerr = 1; tv[3].emargin = 3;
        tv[4].d = '{-5, -3, -7, -3, -100, -9, -4, -20, -6, -3};
        tv[4].len = 10; tv[4].last_at = 9; tv[4].ecls = 1; tv[4].escore = 32'hFFFF_FFFD;
        tv[4].eerr = 0; tv[4].emargin = 0;
        for (int k = 0; k < N; k++) tv[5].d[k] = S_MIN;
        tv[5].d[1] = S_MAX;
        tv[5].len = 10; tv[5].last_at = 9; tv[5].ecls = 1; tv[5].escore = S_MAX;
        tv[5].eerr = 0; tv[5].emargin = S_MAX;
        tv[6].d = '{7, 6, 5, 4, 3, 2, 1, 0, -1, -2};
        tv[6].len = 10; tv[6].last_at = 9; tv[6].ecls = 0; tv[6].escore = 7;
        tv[6].eerr = 0; tv[6].emargin = 1;
        tv[7].d = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7};
        tv[7].len = 10; tv[7].last_at = 9; tv[7].ecls = 9; tv[7].escore = 7;
        tv[7].eerr = 0; tv[7].emargin = 7;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", W'(in_ready), '0);
        chk("rst_out_valid", W'(out_valid), '0);
        check_result("rst", 0, '0, 1'b0, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send_row(i);
            release_result($sformatf("row%0d", i));
        end

        // Consumer stalls for 20 cycles while the producer keeps offering a beat.
        send_row(2);
        in_valid = 1'b1; in_data = 99; in_last = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready || !out_valid || out_class != 4'd2 || out_score != 8 || !out_err) bad++;
        end
        chk("hold_stable", W'(bad), '0);
        release_result("hold");
        push_beat(99, 1'b1, ovb);
        chk("single_latency", W'({ovb, out_valid}), W'(2'b01));
        check_result("single", 0, 99, 1'b1, S_MAX);
        release_result("single");

        // Reset in the middle of a frame discards the partial best.
        for (int b = 0; b < 4; b++) push_beat(W'(50 + 10 * b), 1'b0, ovb);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", W'(in_ready), '0);
        chk("midrst_out_valid", W'(out_valid), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_row(7);
        release_result("row7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
